data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_BUS_WIDTH, 16, byte-address width (shared params include).
REQ-002 SHALL have parameter DATA_BUS_WIDTH, 16, data word width.
REQ-003 SHALL have parameter MEM_BYTES, 64, byte count of the attached data RAM.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  CPU request present.
REQ-007 SHALL have port req_ready  out  1  controller can accept a request.
REQ-008 SHALL have port req_load  in  1  1 = load, 0 = store.
REQ-009 SHALL have port req_byte  in  1  1 = byte access, 0 = 16-bit little-endian word.
REQ-010 SHALL have port req_signed  in  1  sign-extend byte loads.
REQ-011 SHALL have port req_addr  in  ADDRESS_BUS_WIDTH  byte address.
REQ-012 SHALL have port req_wdata  in  DATA_BUS_WIDTH  store data; byte store uses [7:0].
REQ-013 SHALL have port resp_valid  out  1  response present.
REQ-014 SHALL have port resp_ready  in  1  CPU accepts response.
REQ-015 SHALL have port resp_rdata  out  DATA_BUS_WIDTH  load result; 0 for stores and errors.
REQ-016 SHALL have port resp_err  out  1  address out of range; no RAM access made.
REQ-017 SHALL have ports ram_address (out, ADDRESS_BUS_WIDTH), ram_write_data (out, DATA_BUS_WIDTH), ram_read_not_write (out, 1), ram_cs (out, 1), ram_read_data (in, DATA_BUS_WIDTH), driving the data RAM.

Function
REQ-018 All outputs SHALL be registered except req_ready, which SHALL equal (state == IDLE).
REQ-019 States SHALL be IDLE, ACCESS, WAIT, WRITE, RESP.
REQ-020 IDLE: on req_valid, SHALL latch the request; if req_addr > MEM_BYTES-2, go to RESP with resp_err=1, resp_rdata=0, ram_cs held 0.
REQ-021 IDLE, in-range request: SHALL go to ACCESS, driving ram_cs=1, ram_address=req_addr, ram_read_not_write=1 for loads and byte stores, 0 with ram_write_data=req_wdata for word stores.
REQ-022 ACCESS: SHALL drop ram_cs next edge; word store goes to RESP, everything else to WAIT.
REQ-023 WAIT: SHALL sample ram_read_data (valid only this cycle; RAM drives Z otherwise).
REQ-024 WAIT, word load: resp_rdata = ram_read_data; byte load: resp_rdata = {8{sign?rd[7]:0}, rd[7:0]}; go to RESP.
REQ-025 WAIT, byte store: go to WRITE driving ram_cs=1, ram_read_not_write=0, ram_write_data={rd[15:8], req_wdata[7:0]} so RAM[addr+1] is rewritten unchanged.
REQ-026 WRITE: SHALL drop ram_cs next edge and go to RESP.
REQ-027 RESP: resp_valid SHALL be 1 and resp_rdata/resp_err stable until resp_ready=1; then IDLE with resp_valid=0 on that edge.
REQ-028 Latency from accept edge to resp_valid: word store 2, load 3, byte store 4, error 1 cycles.
REQ-029 ram_cs SHALL never be high for more than one consecutive cycle, and never while in IDLE or RESP.
REQ-030 No new request SHALL be accepted before the prior response handshake completes; req_* ignored when req_ready=0.

Reset
REQ-031 reset SHALL force IDLE, resp_valid=0, resp_err=0, resp_rdata=0, ram_cs=0, ram_read_not_write=1, ram_address=0, ram_write_data=0.
REQ-032 Reset mid-operation: a RAM access whose ram_cs=1 was presented in the reset cycle completes in the RAM; the controller SHALL issue no further access and SHALL drop the pending response.
REQ-033 reset SHALL take priority over req_valid and resp_ready in the same cycle.

Verification
REQ-034 Word load addr 16 (RAM[16]=20, RAM[17]=0), resp_ready=1 -> resp_valid 3 cycles after accept, resp_rdata=0x0014, resp_err=0.
REQ-035 Word store 0xBEEF to addr 8, then word load addr 8 -> 0xBEEF; byte loads addr 8 -> 0x00EF unsigned, 0xFFEF signed.
REQ-036 Byte store 0x5A to addr 32 (RAM[32]=22, RAM[33]=0) -> ram_cs pulses twice (read, write), write data 0x005A; word load addr 32 -> 0x005A.
REQ-037 Load addr MEM_BYTES-1 (63) -> resp_valid after 1 cycle, resp_err=1, resp_rdata=0, ram_cs stays 0.
REQ-038 Hold resp_ready=0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, new req_valid ignored.
REQ-039 Assert reset during WAIT of a byte store -> no WRITE cycle, RAM unchanged, all outputs at reset values next cycle.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data memory controller: turns CPU byte/word load/store requests into
// single-cycle chip-select accesses on a 16-bit little-endian data RAM.
// Byte stores are read-modify-write so the neighbouring byte is preserved.
module data_mem_ctrl #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int MEM_BYTES         = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_load,
  input  logic                         req_byte,
  input  logic                         req_signed,
  input  logic [ADDRESS_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_BUS_WIDTH-1:0]    resp_rdata,
  output logic                         resp_err,
  output logic [ADDRESS_BUS_WIDTH-1:0] ram_address,
  output logic [DATA_BUS_WIDTH-1:0]    ram_write_data,
  output logic                         ram_read_not_write,
  output logic                         ram_cs,
  input  logic [DATA_BUS_WIDTH-1:0]    ram_read_data
);

  // Highest address whose word (addr, addr+1) still fits in the RAM.
  localparam logic [ADDRESS_BUS_WIDTH-1:0] LAST_WORD = ADDRESS_BUS_WIDTH'(MEM_BYTES - 2);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, WRITE, RESP} state_e;

  state_e     state_q;
  logic       load_q;
  logic       byte_q;
  logic       signed_q;
  logic [7:0] wbyte_q;   // only the low byte is needed after the accept cycle

  logic [DATA_BUS_WIDTH-1:0] rdata_d;

  assign req_ready = (state_q == IDLE);

  // Format load data: full word, or low byte zero/sign extended.
  always_comb begin
    rdata_d = ram_read_data;
    if (byte_q)
      rdata_d = {{(DATA_BUS_WIDTH-8){signed_q & ram_read_data[7]}}, ram_read_data[7:0]};
  end

  // Controller FSM; every output except req_ready is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      load_q             <= 1'b0;
      byte_q             <= 1'b0;
      signed_q           <= 1'b0;
      wbyte_q            <= '0;
      resp_valid         <= 1'b0;
      resp_err           <= 1'b0;
      resp_rdata         <= '0;
      ram_cs             <= 1'b0;
      ram_read_not_write <= 1'b1;
      ram_address        <= '0;
      ram_write_data     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            load_q   <= req_load;
            byte_q   <= req_byte;
            signed_q <= req_signed;
            wbyte_q  <= req_wdata[7:0];
            if (req_addr > LAST_WORD) begin
              // Out of range: answer immediately, never touch the RAM.
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_q            <= ACCESS;
              ram_cs             <= 1'b1;
              ram_address        <= req_addr;
              // Byte stores start with a read of the containing word.
              ram_read_not_write <= req_load | req_byte;
              if (!req_load && !req_byte)
                ram_write_data <= req_wdata;
            end
          end
        end
        ACCESS: begin
          ram_cs             <= 1'b0;
          ram_read_not_write <= 1'b1;
          if (!load_q && !byte_q) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (load_q) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= rdata_d;
          end else begin
            // Write back the untouched high byte alongside the new low byte.
            state_q            <= WRITE;
            ram_cs             <= 1'b1;
            ram_read_not_write <= 1'b0;
            ram_write_data     <= {ram_read_data[DATA_BUS_WIDTH-1:8], wbyte_q};
          end
        end
        WRITE: begin
          state_q            <= RESP;
          ram_cs             <= 1'b0;
          ram_read_not_write <= 1'b1;
          resp_valid         <= 1'b1;
          resp_err           <= 1'b0;
          resp_rdata         <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state_q    <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized scoreboard bench for data_mem_ctrl with a behavioural byte-array
// reference model and a synchronous RAM model attached to the RAM port.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] ram_address;
  logic [15:0] ram_write_data;
  logic        ram_read_not_write;
  logic        ram_cs;
  logic [15:0] ram_read_data;

  data_mem_ctrl #(.ADDRESS_BUS_WIDTH(16), .DATA_BUS_WIDTH(16), .MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_read_not_write(ram_read_not_write),
    .ram_cs(ram_cs), .ram_read_data(ram_read_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous RAM: read data valid only in the cycle after a read select.
  logic [7:0]  ram [64];
  logic [15:0] rd_q = '0;
  logic        rd_vld = 1'b0;
  assign ram_read_data = rd_vld ? rd_q : 16'hDEAD;
  always @(posedge clk) begin
    rd_vld <= 1'b0;
    if (ram_cs) begin
      if (ram_read_not_write) begin
        rd_q   <= {ram[ram_address[5:0] + 6'd1], ram[ram_address[5:0]]};
        rd_vld <= 1'b1;
      end else begin
        ram[ram_address[5:0]]        <= ram_write_data[7:0];
        ram[ram_address[5:0] + 6'd1] <= ram_write_data[15:8];
      end
    end
  end

  // Reference memory contents as the CPU should see them.
  logic [7:0] mref [64];

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          pulses;
  } exp_t;
  exp_t sbq[$];

  // Monitor: protocol checks every cycle, response checks against the queue.
  int          pulses = 0;
  logic        prev_v = 1'b0;
  logic        prev_cs = 1'b0;
  logic [15:0] held_rd = '0;
  logic        held_err = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      pulses  = 0;
      prev_v  = 1'b0;
      prev_cs = 1'b0;
    end else begin
      if (ram_cs) begin
        chk("cs_consecutive", {31'd0, prev_cs}, 32'd0);
        chk("cs_in_idle_or_resp", {31'd0, req_ready | resp_valid}, 32'd0);
        pulses++;
      end
      if (resp_valid) begin
        chk("req_ready_while_busy", {31'd0, req_ready}, 32'd0);
        if (!prev_v) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: got a response, expected none (cycle %0d)", cyc);
          end else begin
            chk("latency", cyc - sbq[0].acc, sbq[0].lat);
            chk("cs_pulses", pulses, sbq[0].pulses);
          end
        end else begin
          chk("hold_rdata", {16'd0, resp_rdata}, {16'd0, held_rd});
          chk("hold_err", {31'd0, resp_err}, {31'd0, held_err});
        end
        held_rd  = resp_rdata;
        held_err = resp_err;
        if (resp_ready && sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("rdata", {16'd0, resp_rdata}, {16'd0, e.rdata});
          chk("err", {31'd0, resp_err}, {31'd0, e.err});
          pulses = 0;
        end
      end
      prev_v  = resp_valid;
      prev_cs = ram_cs;
    end
  end

  // Issue one request, compute its expected outcome from the reference
  // memory, then let the response sit for 'hold' cycles before accepting.
  task automatic issue(input bit ld, input bit bt, input bit sg,
                       input logic [15:0] a, input logic [15:0] wd, input int hold);
    exp_t e;
    int   ia;
    bit   seen;
    ia = int'(a);
    e.rdata = '0; e.err = 1'b0; e.pulses = 1;
    if (ia > 62) begin
      e.err = 1'b1; e.lat = 1; e.pulses = 0;
    end else if (ld) begin
      e.lat = 3;
      if (bt) e.rdata = {{8{sg & mref[ia][7]}}, mref[ia]};
      else    e.rdata = {mref[ia+1], mref[ia]};
    end else if (bt) begin
      e.lat = 4; e.pulses = 2;
      mref[ia] = wd[7:0];
    end else begin
      e.lat = 2;
      mref[ia]   = wd[7:0];
      mref[ia+1] = wd[15:8];
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_load = ld; req_byte = bt; req_signed = sg;
    req_addr = a; req_wdata = wd; resp_ready = 1'b0;
    @(posedge clk); #1;
    e.acc = cyc - 1;
    sbq.push_back(e);
    // Keep presenting in-range junk while busy; it must be ignored.
    req_load = $urandom_range(0, 1); req_byte = $urandom_range(0, 1);
    req_addr = 16'($urandom_range(0, 62)); req_wdata = 16'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (resp_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL resp_timeout: got no response, expected one for addr 0x%0h", a);
    end
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_resp_rdata"}, {16'd0, resp_rdata}, 32'd0);
    chk({tag, "_ram_cs"}, {31'd0, ram_cs}, 32'd0);
    chk({tag, "_ram_rnw"}, {31'd0, ram_read_not_write}, 32'd1);
    chk({tag, "_ram_address"}, {16'd0, ram_address}, 32'd0);
    chk({tag, "_ram_wdata"}, {16'd0, ram_write_data}, 32'd0);
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < 64; i++) begin
      ram[i]  = 8'($urandom);
      mref[i] = ram[i];
    end
    ram[16] = 8'd20; ram[17] = 8'd0; ram[32] = 8'd22; ram[33] = 8'd0;
    mref[16] = 8'd20; mref[17] = 8'd0; mref[32] = 8'd22; mref[33] = 8'd0;

    // Reset wins over a simultaneous request and response accept.
    req_valid = 1'b1; req_load = 1'b1; req_addr = 16'd4; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;

    issue(1, 0, 0, 16'd16, 16'h0, 0);            // word load -> 0x0014
    issue(0, 0, 0, 16'd8, 16'hBEEF, 1);          // word store
    issue(1, 0, 0, 16'd8, 16'h0, 0);             // -> 0xBEEF
    issue(1, 1, 0, 16'd8, 16'h0, 0);             // -> 0x00EF
    issue(1, 1, 1, 16'd8, 16'h0, 2);             // -> 0xFFEF
    issue(0, 1, 0, 16'd32, 16'h005A, 0);         // byte store, two selects
    issue(1, 0, 0, 16'd32, 16'h0, 0);            // -> 0x005A
    issue(1, 0, 0, 16'd63, 16'h0, 0);            // error, last byte
    issue(1, 0, 0, 16'd62, 16'h0, 0);            // last legal word
    issue(0, 1, 0, 16'hFFFF, 16'h1234, 0);       // error store
    issue(1, 0, 0, 16'd16, 16'h0, 5);            // response held 5 cycles

    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(63, 65535))
                                       : 16'($urandom_range(0, 62));
      issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            a, 16'($urandom), $urandom_range(0, 3));
    end

    // Reset during WAIT of a byte store: no write-back, outputs cleared.
    @(posedge clk); #1;
    req_valid = 1'b1; req_load = 1'b0; req_byte = 1'b1; req_addr = 16'd40;
    req_wdata = 16'h00C3; resp_ready = 1'b0;
    @(posedge clk); #1;                          // accepted, now ACCESS
    req_valid = 1'b0;
    @(posedge clk); #1;                          // now WAIT
    reset = 1'b1; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    chk_reset_outputs("midreset");
    repeat (3) begin @(posedge clk); #1; end
    chk("midreset_ram40", {24'd0, ram[40]}, {24'd0, mref[40]});
    chk("midreset_ram41", {24'd0, ram[41]}, {24'd0, mref[41]});
    issue(1, 0, 0, 16'd40, 16'h0, 0);

    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_empty", sbq.size(), 0);
    diffs = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== mref[i]) diffs++;
    chk("ram_contents_diffs", diffs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
